result_packetizer: RTL and testbench

- Transmit-side counterpart of the 48-bit packet collector.
- Accepts one result per request (float, or int/frec pair) tagged with app and size, and serialises it into one or two 48-bit words on `dataout`.
- Output word layout: app[47:46], size[45:43], packet[42:40], data[39:0].
- Valid/ready on both sides; drives all-zero idle words (app=00) when it has nothing to send, so the receiver deasserts its enables.

---
 rtl/result_packetizer.sv | 150 +++++++++++++++
 tb/tb_result_packetizer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/result_packetizer.sv
// Serialises one float or int/frec result per request into one or two 48-bit
// words {app, size, packet, data}; drives all-zero idle words otherwise.
module result_packetizer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_app,
  input  logic [2:0]       in_size,
  input  logic [39:0]      in_int,
  input  logic [39:0]      in_frec,
  input  logic [79:0]      in_float,
  output logic [47:0]      dataout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] drop_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and a presented word holds until taken.
  typedef enum logic [1:0] {IDLE, SEND1, SEND2} state_t;

  state_t           state, state_nxt;
  logic [1:0]       h_app;
  logic [2:0]       h_size;
  logic [39:0]      h_int, h_frec;
  logic [79:0]      h_float;
  logic             accept, legal;
  logic [47:0]      dataout_nxt;
  logic             out_valid_nxt, drop_pulse_nxt;
  logic [CNT_W-1:0] drop_cnt_nxt;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign legal    = ((in_app == 2'b01) || (in_app == 2'b10)) &&
                    ((in_size == 3'b001) || (in_size == 3'b010) || (in_size == 3'b011));

  function automatic logic [47:0] make_word(input logic [1:0]  app,
                                            input logic [2:0]  size,
                                            input logic [2:0]  pkt,
                                            input logic [39:0] vi,
                                            input logic [39:0] vf,
                                            input logic [79:0] fl);
    logic [39:0] d;
    d = '0;
    if (app == 2'b01) begin
      if (size == 3'b001)      d = {fl[31:0], 8'h00};
      else if (pkt == 3'b001)  d = fl[79:40];
      else                     d = fl[39:0];
    end else begin
      case (size)
        3'b001:  d = {vi[15:0], vf[15:0], 8'h00};
        3'b010:  d = (pkt == 3'b001) ? {vi[31:0], 8'h00} : {vf[31:0], 8'h00};
        default: d = (pkt == 3'b001) ? vi : vf;
      endcase
    end
    return {app, size, pkt, d};
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      dataout    <= '0;
      out_valid  <= 1'b0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
      h_app      <= '0;
      h_size     <= '0;
      h_int      <= '0;
      h_frec     <= '0;
      h_float    <= '0;
    end else begin
      state      <= state_nxt;
      dataout    <= dataout_nxt;
      out_valid  <= out_valid_nxt;
      drop_pulse <= drop_pulse_nxt;
      drop_cnt   <= drop_cnt_nxt;
      if (accept) begin
        h_app   <= in_app;
        h_size  <= in_size;
        h_int   <= in_int;
        h_frec  <= in_frec;
        h_float <= in_float;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && legal) state_nxt = SEND1;
      SEND1:   if (out_ready) state_nxt = (h_size == 3'b001) ? IDLE : SEND2;
      SEND2:   if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat 1 is built from the live inputs so it appears the cycle after accept;
  // beat 2 comes from the holding registers.
  always_comb begin
    dataout_nxt    = dataout;
    out_valid_nxt  = out_valid;
    drop_pulse_nxt = 1'b0;
    drop_cnt_nxt   = drop_cnt;
    case (state)
      IDLE: begin
        dataout_nxt   = '0;
        out_valid_nxt = 1'b0;
        if (accept) begin
          if (legal) begin
            dataout_nxt   = make_word(in_app, in_size,
                                      (in_size == 3'b001) ? 3'b000 : 3'b001,
                                      in_int, in_frec, in_float);
            out_valid_nxt = 1'b1;
          end else begin
            drop_pulse_nxt = 1'b1;
            if (drop_cnt != {CNT_W{1'b1}}) drop_cnt_nxt = drop_cnt + CNT_W'(1);
          end
        end
      end
      SEND1: begin
        if (out_ready) begin
          if (h_size == 3'b001) begin
            dataout_nxt   = '0;
            out_valid_nxt = 1'b0;
          end else begin
            dataout_nxt   = make_word(h_app, h_size, 3'b010, h_int, h_frec, h_float);
            out_valid_nxt = 1'b1;
          end
        end
      end
      SEND2: begin
        if (out_ready) begin
          dataout_nxt   = '0;
          out_valid_nxt = 1'b0;
        end
      end
      default: begin
        dataout_nxt   = '0;
        out_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_result_packetizer.sv
// Directed and randomized checks of result_packetizer against a word-list
// reference model built from the packet layout rules.
module tb_result_packetizer;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_app = '0;
  logic [2:0]       in_size = '0;
  logic [39:0]      in_int = '0;
  logic [39:0]      in_frec = '0;
  logic [79:0]      in_float = '0;
  logic [47:0]      dataout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             drop_pulse;
  logic [CNT_W-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int exp_drops = 0;
  logic [47:0] exp_q[$];

  result_packetizer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_app(in_app), .in_size(in_size), .in_int(in_int), .in_frec(in_frec),
    .in_float(in_float), .dataout(dataout), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [1:0] app, input logic [2:0] size);
    return ((app == 2'd1) || (app == 2'd2)) && (size >= 3'd1) && (size <= 3'd3);
  endfunction

  function automatic logic [47:0] word_of(input logic [1:0] app, input logic [2:0] size,
                                          input int pkt, input logic [39:0] data);
    logic [47:0] w;
    w = (48'(app) << 46) | (48'(size) << 43) | (48'(pkt) << 40) | 48'(data);
    return w;
  endfunction

  // Expected words for one legal request, appended in emission order.
  task automatic model_push(input logic [1:0] app, input logic [2:0] size,
                            input logic [39:0] vi, input logic [39:0] vf,
                            input logic [79:0] fl);
    logic [39:0] lo16_i, lo16_f, lo32_i, lo32_f, lo32_fl;
    lo16_i  = vi % 40'h10000;
    lo16_f  = vf % 40'h10000;
    lo32_i  = vi % 40'h100000000;
    lo32_f  = vf % 40'h100000000;
    lo32_fl = 40'(fl % 80'h100000000);
    if (app == 2'd1) begin
      if (size == 3'd1) exp_q.push_back(word_of(app, size, 0, lo32_fl * 256));
      else begin
        exp_q.push_back(word_of(app, size, 1, 40'(fl / (80'd1 << 40))));
        exp_q.push_back(word_of(app, size, 2, 40'(fl % (80'd1 << 40))));
      end
    end else begin
      if (size == 3'd1) exp_q.push_back(word_of(app, size, 0, lo16_i * 40'h1000000 + lo16_f * 256));
      else if (size == 3'd2) begin
        exp_q.push_back(word_of(app, size, 1, lo32_i * 256));
        exp_q.push_back(word_of(app, size, 2, lo32_f * 256));
      end else begin
        exp_q.push_back(word_of(app, size, 1, vi));
        exp_q.push_back(word_of(app, size, 2, vf));
      end
    end
  endtask

  task automatic scramble_inputs();
    in_app   = 2'($urandom);
    in_size  = 3'($urandom);
    in_int   = {8'($urandom), 32'($urandom)};
    in_frec  = {8'($urandom), 32'($urandom)};
    in_float = {16'($urandom), 32'($urandom), 32'($urandom)};
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic send_legal(input logic [1:0] app, input logic [2:0] size,
                            input logic [39:0] vi, input logic [39:0] vf,
                            input logic [79:0] fl, input int stall1, input int stall2);
    logic [47:0] exp;
    int stall;
    int bi;
    model_push(app, size, vi, vf, fl);
    chk("idle_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_app = app; in_size = size;
    in_int = vi; in_frec = vf; in_float = fl;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    scramble_inputs();
    bi = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      stall = (bi == 0) ? stall1 : stall2;
      for (int s = 0; s <= stall; s++) begin
        out_ready = (s == stall);
        chk("beat_valid", 64'(out_valid), 64'd1);
        chk("beat_data", 64'(dataout), 64'(exp));
        chk("busy_ready", 64'(in_ready), 64'd0);
        chk("busy_flag", 64'(busy), 64'd1);
        @(negedge clk);
      end
      bi++;
    end
    out_ready = 1'b0;
    chk("end_valid", 64'(out_valid), 64'd0);
    chk("end_data", 64'(dataout), 64'd0);
    chk("end_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic send_illegal(input logic [1:0] app, input logic [2:0] size);
    in_valid = 1'b1; in_app = app; in_size = size;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    exp_drops = (exp_drops + 1 > CNT_MAX) ? CNT_MAX : exp_drops + 1;
    chk("drop_pulse_hi", 64'(drop_pulse), 64'd1);
    chk("drop_no_valid", 64'(out_valid), 64'd0);
    chk("drop_data", 64'(dataout), 64'd0);
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
    chk("drop_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("drop_pulse_lo", 64'(drop_pulse), 64'd0);
  endtask

  initial begin
    logic [1:0]  r_app;
    logic [2:0]  r_size;
    logic [47:0] exp;

    repeat (3) @(negedge clk);
    rstn = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(dataout), 64'd0);
    chk("rst_pulse", 64'(drop_pulse), 64'd0);
    chk("rst_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);

    // Directed cases
    send_legal(2'b01, 3'b001, 40'h0, 40'h0, 80'h3F800000, 0, 0);
    send_legal(2'b10, 3'b001, 40'h1234, 40'hABCD, 80'h0, 0, 0);
    send_legal(2'b01, 3'b010, 40'h0, 40'h0, 80'h0102030405060708090A, 0, 0);
    send_legal(2'b10, 3'b011, 40'h1122334455, 40'h66778899AA, 80'h0, 3, 0);
    send_illegal(2'b11, 3'b001);
    send_illegal(2'b01, 3'b100);
    chk("drop_two", 64'(drop_cnt), 64'd2);

    // Saturation with back-to-back illegal requests
    in_valid = 1'b1; in_app = 2'b00; in_size = 3'b001;
    repeat (300) @(negedge clk);
    in_valid = 1'b0;
    exp_drops = (exp_drops + 300 > CNT_MAX) ? CNT_MAX : exp_drops + 300;
    chk("drop_saturate", 64'(drop_cnt), 64'(exp_drops));
    @(negedge clk);
    chk("drop_saturate_hold", 64'(drop_cnt), 64'd255);

    // Randomized mix of legal and illegal requests
    for (int i = 0; i < 40; i++) begin
      r_app  = 2'($urandom_range(0, 3));
      r_size = 3'($urandom_range(0, 4));
      if (is_legal(r_app, r_size))
        send_legal(r_app, r_size, {8'($urandom), 32'($urandom)}, {8'($urandom), 32'($urandom)},
                   {16'($urandom), 32'($urandom), 32'($urandom)},
                   $urandom_range(0, 3), $urandom_range(0, 3));
      else
        send_illegal(r_app, r_size);
    end

    // Reset between beat 1 and beat 2
    in_float = {16'($urandom), 32'($urandom), 32'($urandom)};
    model_push(2'b01, 3'b011, 40'h0, 40'h0, in_float);
    in_valid = 1'b1; in_app = 2'b01; in_size = 3'b011;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    exp = exp_q.pop_front();
    chk("rstmid_beat1", 64'(dataout), 64'(exp));
    @(negedge clk);
    out_ready = 1'b0;
    exp = exp_q.pop_front();
    chk("rstmid_beat2_shown", 64'(dataout), 64'(exp));
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_drops = 0;
    chk("rstmid_valid", 64'(out_valid), 64'd0);
    chk("rstmid_data", 64'(dataout), 64'd0);
    chk("rstmid_ready", 64'(in_ready), 64'd1);
    chk("rstmid_cnt", 64'(drop_cnt), 64'(exp_drops));
    out_ready = 1'b1;
    @(negedge clk);
    chk("rstmid_no_beat2", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    send_legal(2'b10, 3'b010, 40'hAA_DEADBEEF, 40'h55_CAFEF00D, 80'h0, 1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
